// File: rtl/dts_result_collector.sv
// dts_result_collector: polls the DTS search array, reads its result rows and streams them downstream
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   snapshot_req        host progress-dump request, held pending until served from IDLE
//   doneAggregate       a worker holds a solution (only looked at in IDLE)
//   poll / ready        start array fill / array result RAM is filled and held
//   rowAddr / row       result RAM read port, one-cycle registered read latency
//   anotherOneBroadcast restart pulse to the workers after a solution frame
//   out_*               downstream row stream with valid/ready handshake and frame delimiters
//   result_count        completed solution frames (wrapping)
//   timeout_err         sticky flag: the array never raised ready for a frame
//   busy                high whenever the collector is not IDLE
module dts_result_collector #(
  parameter int n = 3,
  parameter int M = 19,
  parameter int GUARD_CYCLES = 3,
  parameter int READY_TIMEOUT = 1024,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                snapshot_req,
  input  logic                                doneAggregate,
  input  logic                                ready,
  output logic                                poll,
  output logic [(n > 1 ? $clog2(n) : 1)-1:0] rowAddr,
  input  logic [M:0]                          row,
  output logic                                anotherOneBroadcast,
  output logic [M:0]                          out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_first,
  output logic                                out_last,
  output logic                                out_found,
  output logic [15:0]                         result_count,
  output logic                                timeout_err,
  output logic                                busy
);
  localparam int AW = n > 1 ? $clog2(n) : 1;
  localparam int CMAX0 = GUARD_CYCLES > COOLDOWN_CYCLES ? GUARD_CYCLES : COOLDOWN_CYCLES;
  localparam int CMAX = CMAX0 > READY_TIMEOUT ? CMAX0 : READY_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [3:0] {IDLE, POLL, GUARD, WAIT_READY, FETCH, CAPTURE, SEND, RELEASE, COOLDOWN} stateT;

  stateT         state;
  logic [AW-1:0] i;
  logic [CW-1:0] cnt;
  logic          snapPending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      poll                <= 1'b0;
      anotherOneBroadcast <= 1'b0;
      out_valid           <= 1'b0;
      out_first           <= 1'b0;
      out_last            <= 1'b0;
      out_found           <= 1'b0;
      busy                <= 1'b0;
      timeout_err         <= 1'b0;
      rowAddr             <= '0;
      out_data            <= '0;
      result_count        <= '0;
      snapPending         <= 1'b0;
      i                   <= '0;
      cnt                 <= '0;
    end else begin
      case (state)
        IDLE: if (doneAggregate || snapPending) begin
          state       <= POLL;
          poll        <= 1'b1;
          busy        <= 1'b1;
          out_found   <= doneAggregate;
          snapPending <= 1'b0;
        end
        POLL: begin
          state <= GUARD;
          poll  <= 1'b0;
          i     <= '0;
          cnt   <= '0;
        end
        // ready may still be asserted from the previous frame; ignore it here
        GUARD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(GUARD_CYCLES - 1)) begin
            state <= WAIT_READY;
            cnt   <= '0;
          end
        end
        WAIT_READY: if (ready) begin
          state   <= FETCH;
          rowAddr <= i;
        end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
          state       <= IDLE;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          state     <= SEND;
          out_data  <= row;
          out_first <= i == '0;
          out_last  <= i == AW'(n - 1);
          out_valid <= 1'b1;
        end
        // out_valid is always high in SEND, so out_ready alone marks the handshake
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          if (!out_last) begin
            state   <= FETCH;
            i       <= i + 1'b1;
            rowAddr <= i + 1'b1;
          end else if (out_found) begin
            state               <= RELEASE;
            anotherOneBroadcast <= 1'b1;
            result_count        <= result_count + 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RELEASE: begin
          state               <= COOLDOWN;
          anotherOneBroadcast <= 1'b0;
          cnt                 <= '0;
        end
        COOLDOWN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(COOLDOWN_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // a request in the same cycle a frame starts survives the clear above
      if (snapshot_req) snapPending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dts_result_collector.sv
// tb_dts_result_collector: scoreboard bench with a behavioural DTS array model for dts_result_collector
module tb_dts_result_collector;
  localparam int n = 3, M = 19, GUARD = 3, TMO = 1024, COOL = 4, AW = 2;

  logic clk = 1'b0, reset = 1'b1, snapshot_req = 1'b0, doneAggregate = 1'b0, ready = 1'b0, out_ready = 1'b1;
  logic poll, anotherOneBroadcast, out_valid, out_first, out_last, out_found, timeout_err, busy;
  logic [AW-1:0] rowAddr;
  logic [M:0] row = '0;
  logic [M:0] out_data;
  logic [15:0] result_count;

  logic [M:0] ram [n] = '{default: '0};
  logic [M:0] nextRows [n] = '{default: '0};
  logic staleMode = 1'b0;
  int readyDelay = 5, rcnt = 0, cyc = 0;
  int checks = 0, errors = 0, words = 0, bcasts = 0;
  int pollCyc = 0, firstVal = -1, bcastCyc = 0, lastHs = 0;
  logic [M+3:0] expQ [$];
  logic [M+3:0] e;

  dts_result_collector dut (
    .clk(clk), .reset(reset), .snapshot_req(snapshot_req), .doneAggregate(doneAggregate),
    .ready(ready), .poll(poll), .rowAddr(rowAddr), .row(row),
    .anotherOneBroadcast(anotherOneBroadcast), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last), .out_found(out_found),
    .result_count(result_count), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Array model: registered RAM read, RAM refilled 3 cycles after poll, ready raised readyDelay
  // cycles after poll (never when 0); in staleMode ready stays high throughout.
  always @(posedge clk) begin
    row <= ram[rowAddr];
    if (poll) rcnt <= 1;
    else if (rcnt != 0) rcnt <= rcnt + 1;
    if (rcnt == 2) for (int j = 0; j < n; j++) ram[j] <= nextRows[j];
    ready <= staleMode | (poll ? 1'b0 : (ready | (readyDelay != 0 && rcnt == readyDelay - 1)));
  end

  always @(negedge clk) if (!reset) begin
    if (poll) begin pollCyc = cyc; firstVal = -1; end
    if (out_valid && firstVal < 0) firstVal = cyc;
    if (anotherOneBroadcast) begin bcasts++; bcastCyc = cyc; end
    if (out_valid && out_ready) begin
      words++;
      lastHs = cyc;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got data=%h, required no word", out_data);
      end else begin
        e = expQ.pop_front();
        if ({out_data, out_first, out_last, out_found} !== e) begin
          errors++;
          $display("FAIL word: got data=%h first=%b last=%b found=%b, required data=%h first=%b last=%b found=%b",
                   out_data, out_first, out_last, out_found, e[M+3:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int sel);
    return sel == 0 ? poll : sel == 1 ? !busy : sel == 2 ? out_valid : sel == 3 ? timeout_err : anotherOneBroadcast;
  endfunction

  task automatic wait_for(input int sel, input int limit, input string name);
    int k;
    k = 0;
    checks++;
    while (!cond(sel) && k < limit) begin @(negedge clk); k++; end
    if (!cond(sel)) begin
      errors++;
      $display("FAIL %s: got no event within %0d cycles, required event", name, limit);
    end
  endtask

  task automatic set_rows(input logic [M:0] a, input logic [M:0] b, input logic [M:0] c);
    nextRows[0] = a;
    nextRows[1] = b;
    nextRows[2] = c;
  endtask

  task automatic push_frame(input logic f);
    for (int j = 0; j < n; j++) expQ.push_back({nextRows[j], j == 0, j == n - 1, f});
  endtask

  task automatic pulse_snapshot();
    tick(); snapshot_req = 1'b1;
    tick(); snapshot_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({poll, anotherOneBroadcast, out_valid, out_first, out_last, out_found, timeout_err, busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {poll, anotherOneBroadcast, out_valid, out_first, out_last, out_found, timeout_err, busy});
    end
    checks++;
    if (rowAddr !== 2'd0 || out_data !== 20'd0) begin
      errors++; $display("FAIL reset_data: got rowAddr=%0d data=%h, required 0 0", rowAddr, out_data);
    end
    checks++;
    if (result_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", result_count); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_found();
    int w0, b0;
    w0 = words; b0 = bcasts;
    readyDelay = 5;
    set_rows(20'h00013, 20'h00A05, 20'h40001);
    push_frame(1'b1);
    tick(); doneAggregate = 1'b1;
    @(negedge clk);
    checks++;
    if (poll !== 1'b0) begin errors++; $display("FAIL poll_early: got %b, required 0", poll); end
    @(negedge clk);
    checks++;
    if (poll !== 1'b1) begin errors++; $display("FAIL poll_start: got %b, required 1", poll); end
    tick(); doneAggregate = 1'b0;
    @(negedge clk);
    checks++;
    if (poll !== 1'b0) begin errors++; $display("FAIL poll_width: got %b, required 0", poll); end
    wait_for(1, 200, "found_idle");
    checks++;
    if (words - w0 !== 3) begin errors++; $display("FAIL found_words: got %0d, required 3", words - w0); end
    checks++;
    if (bcasts - b0 !== 1) begin errors++; $display("FAIL found_bcast: got %0d, required 1", bcasts - b0); end
    checks++;
    if (bcastCyc !== lastHs + 1) begin
      errors++; $display("FAIL bcast_timing: got cycle %0d, required %0d", bcastCyc, lastHs + 1);
    end
    checks++;
    if (result_count !== 16'd1) begin errors++; $display("FAIL found_count: got %0d, required 1", result_count); end
  endtask

  task automatic test_snapshot();
    int w0, b0;
    w0 = words; b0 = bcasts;
    set_rows(20'h12345, 20'h0F0F0, 20'hFFFFF);
    push_frame(1'b0);
    pulse_snapshot();
    wait_for(0, 20, "snap_poll");
    wait_for(1, 200, "snap_idle");
    checks++;
    if (words - w0 !== 3) begin errors++; $display("FAIL snap_words: got %0d, required 3", words - w0); end
    checks++;
    if (bcasts !== b0) begin errors++; $display("FAIL snap_bcast: got %0d, required 0", bcasts - b0); end
    checks++;
    if (result_count !== 16'd1) begin errors++; $display("FAIL snap_count: got %0d, required 1", result_count); end
  endtask

  task automatic test_stale_ready();
    staleMode = 1'b1;
    set_rows(20'h00777, 20'h88800, 20'h0ABCD);
    push_frame(1'b1);
    tick(); tick();
    doneAggregate = 1'b1;
    wait_for(0, 20, "stale_poll");
    tick(); doneAggregate = 1'b0;
    wait_for(1, 200, "stale_idle");
    checks++;
    if (firstVal - pollCyc !== GUARD + 4) begin
      errors++; $display("FAIL stale_guard: got first word %0d cycles after poll, required %0d", firstVal - pollCyc, GUARD + 4);
    end
    checks++;
    if (result_count !== 16'd2) begin errors++; $display("FAIL stale_count: got %0d, required 2", result_count); end
    staleMode = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [M:0] saved;
    int k;
    set_rows(20'h31415, 20'h92653, 20'h58979);
    push_frame(1'b1);
    tick(); doneAggregate = 1'b1;
    wait_for(0, 20, "bp_poll");
    tick(); doneAggregate = 1'b0;
    wait_for(2, 50, "bp_word0");
    tick(); out_ready = 1'b0;
    wait_for(2, 20, "bp_word1");
    saved = out_data;
    checks++;
    if (rowAddr !== 2'd1) begin errors++; $display("FAIL bp_addr: got %0d, required 1", rowAddr); end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== saved || rowAddr !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold: got valid=%b data=%h addr=%0d, required 1 %h 1", out_valid, out_data, rowAddr, saved);
      end
    end
    tick(); out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b, required 1", out_valid); end
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 10);
    checks++;
    if (k !== 3) begin errors++; $display("FAIL bp_spacing: got %0d cycles, required 3", k); end
    wait_for(1, 200, "bp_idle");
    checks++;
    if (result_count !== 16'd3) begin errors++; $display("FAIL bp_count: got %0d, required 3", result_count); end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = words;
    readyDelay = 0;
    pulse_snapshot();
    wait_for(0, 20, "tmo_poll");
    wait_for(3, TMO + 100, "tmo_set");
    checks++;
    if (cyc - pollCyc !== GUARD + TMO + 1) begin
      errors++; $display("FAIL tmo_timing: got %0d cycles after poll, required %0d", cyc - pollCyc, GUARD + TMO + 1);
    end
    checks++;
    if (busy !== 1'b0 || words !== w0) begin
      errors++; $display("FAIL tmo_abort: got busy=%b words=%0d, required 0 0", busy, words - w0);
    end
    readyDelay = 5;
    set_rows(20'h00001, 20'h00002, 20'h00004);
    push_frame(1'b0);
    pulse_snapshot();
    wait_for(0, 20, "tmo_repoll");
    wait_for(1, 200, "tmo_idle");
    checks++;
    if (words - w0 !== 3 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_after: got words=%0d err=%b, required 3 1", words - w0, timeout_err);
    end
  endtask

  task automatic test_priority();
    int w0, b0;
    w0 = words; b0 = bcasts;
    set_rows(20'hAAAAA, 20'h55555, 20'h0F00F);
    push_frame(1'b1);
    tick(); doneAggregate = 1'b1; snapshot_req = 1'b1;
    tick(); snapshot_req = 1'b0;
    wait_for(0, 20, "prio_poll");
    tick(); doneAggregate = 1'b0;
    wait_for(4, 200, "prio_bcast");
    set_rows(20'h11111, 20'h22222, 20'h33333);
    push_frame(1'b0);
    wait_for(0, 50, "prio_poll2");
    checks++;
    if (cyc - bcastCyc !== COOL + 2) begin
      errors++; $display("FAIL prio_cooldown: got %0d cycles, required %0d", cyc - bcastCyc, COOL + 2);
    end
    wait_for(1, 200, "prio_idle");
    checks++;
    if (words - w0 !== 6 || bcasts - b0 !== 1) begin
      errors++; $display("FAIL prio_frames: got words=%0d bcasts=%0d, required 6 1", words - w0, bcasts - b0);
    end
    checks++;
    if (result_count !== 16'd4) begin errors++; $display("FAIL prio_count: got %0d, required 4", result_count); end
  endtask

  task automatic test_reset_mid();
    int w0, b0;
    w0 = words; b0 = bcasts;
    set_rows(20'h0CAFE, 20'h0BEEF, 20'h0D00D);
    push_frame(1'b1);
    out_ready = 1'b0;
    tick(); doneAggregate = 1'b1;
    wait_for(0, 20, "rst_poll");
    tick(); doneAggregate = 1'b0;
    wait_for(2, 50, "rst_send");
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({poll, anotherOneBroadcast, out_valid, out_first, out_last, out_found, timeout_err, busy} !== 8'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b, required 00000000",
               {poll, anotherOneBroadcast, out_valid, out_first, out_last, out_found, timeout_err, busy});
    end
    checks++;
    if (rowAddr !== 2'd0 || out_data !== 20'd0 || result_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_data: got addr=%0d data=%h count=%0d, required 0 0 0", rowAddr, out_data, result_count);
    end
    expQ.delete();
    out_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (bcasts !== b0 || words !== w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got bcasts=%0d words=%0d busy=%b, required 0 0 0", bcasts - b0, words - w0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_found();
    test_snapshot();
    test_stale_ready();
    test_backpressure();
    test_timeout();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
